// File: rtl/soneo_stream_pkg.sv
// Shared helpers for the channel-interleaved sample stream blocks.
package soneo_stream_pkg;

   localparam int DEF_NR_CHANNELS = 3;
   localparam int DEF_INPUT_WIDTH = 24;

   // Channel index width: at least one bit, even for a single channel.
   function automatic int chw(input int nr_channels);
      return (nr_channels > 2) ? $clog2(nr_channels) : 1;
   endfunction

   // Bit offset of channel k inside a packed frame of w-bit samples.
   function automatic int frame_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Frame input and serial sample output handshakes of the frame serializer.
interface frame_serializer_if
   import soneo_stream_pkg::*;
#(
   parameter int NR_CHANNELS = DEF_NR_CHANNELS,
   parameter int INPUT_WIDTH = DEF_INPUT_WIDTH
);
   localparam int CHW = chw(NR_CHANNELS);

   logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_frame_d;
   logic                               s_frame_dv;
   logic                               s_frame_dr;
   logic [INPUT_WIDTH-1:0]             m_ser_d;
   logic [CHW-1:0]                     m_ser_ch;
   logic                               m_ser_dv;
   logic                               m_ser_dr;

   modport slave (
      input  s_frame_d, s_frame_dv, m_ser_dr,
      output s_frame_dr, m_ser_d, m_ser_ch, m_ser_dv
   );

   modport master (
      output s_frame_d, s_frame_dv, m_ser_dr,
      input  s_frame_dr, m_ser_d, m_ser_ch, m_ser_dv
   );
endinterface

// File: rtl/frame_serializer_buf.sv
// Two-slot frame ping-pong buffer with write and pop strobes.
module frame_buf2 #(
   parameter int FRAME_W = 72
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [FRAME_W-1:0] wr_data,
   input  logic               pop,
   output logic [FRAME_W-1:0] rd_data,
   output logic               full,
   output logic               empty
);
   logic [FRAME_W-1:0] slot [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic               do_wr;
   logic               do_pop;

   assign do_wr  = wr_en & ~full;
   assign do_pop = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (do_wr) begin
            slot[wr_ptr] <= wr_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_wr, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = slot[rd_ptr];
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
endmodule

// File: rtl/frame_serializer.sv
// Buffers parallel frames and emits their samples one per transfer in channel order.
module frame_serializer
   import soneo_stream_pkg::*;
#(
   parameter int NR_CHANNELS = DEF_NR_CHANNELS,
   parameter int INPUT_WIDTH = DEF_INPUT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   frame_serializer_if.slave bus,
   input  logic              mute,
   input  logic              clr_underrun,
   output logic              underrun
);
   localparam int             CHW     = chw(NR_CHANNELS);
   localparam int             FRAME_W = NR_CHANNELS * INPUT_WIDTH;
   localparam logic [CHW-1:0] LAST_CH = CHW'(NR_CHANNELS - 1);

   logic               rdy_en;
   logic               full;
   logic               empty;
   logic               armed;
   logic               frame_wr;
   logic               ser_xfer;
   logic               pop;
   logic [CHW-1:0]     ch;
   logic [FRAME_W-1:0] wr_frame;
   logic [FRAME_W-1:0] rd_frame;

   // rdy_en keeps frame ready low while rst is asserted.
   assign bus.s_frame_dr = rdy_en & ~full;
   assign frame_wr       = bus.s_frame_dv & bus.s_frame_dr;
   assign ser_xfer       = bus.m_ser_dv & bus.m_ser_dr;
   assign pop            = ser_xfer & (ch == LAST_CH);
   assign wr_frame       = mute ? '0 : bus.s_frame_d;

   frame_buf2 #(
      .FRAME_W (FRAME_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (frame_wr),
      .wr_data (wr_frame),
      .pop     (pop),
      .rd_data (rd_frame),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_en   <= 1'b0;
         armed    <= 1'b0;
         ch       <= '0;
         underrun <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (frame_wr)
            armed <= 1'b1;
         if (ser_xfer)
            ch <= (ch == LAST_CH) ? '0 : ch + CHW'(1);
         // A starvation event outranks a same-cycle clear.
         if (armed && bus.m_ser_dr && empty)
            underrun <= 1'b1;
         else if (clr_underrun)
            underrun <= 1'b0;
      end
   end

   assign bus.m_ser_dv = ~empty;
   assign bus.m_ser_ch = ch;
   assign bus.m_ser_d  = INPUT_WIDTH'(rd_frame >> frame_lsb(int'(ch), INPUT_WIDTH));
endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: table vectors, scoreboard and corner sequences.
module tb_frame_serializer;
   import soneo_stream_pkg::*;

   localparam int NR = 3;
   localparam int W  = 24;
   localparam int CW = chw(NR);

   typedef struct {
      logic [NR*W-1:0] frame;
      logic            m;
      logic [NR*W-1:0] exp;
   } vec_t;

   typedef struct {
      logic [W-1:0]  d;
      logic [CW-1:0] ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mute = 1'b0, clr_underrun = 1'b0, underrun;
   logic mute1 = 1'b0, clr1 = 1'b0, underrun1;

   always #5 clk = ~clk;

   frame_serializer_if #(.NR_CHANNELS(NR), .INPUT_WIDTH(W)) bus ();
   frame_serializer_if #(.NR_CHANNELS(1), .INPUT_WIDTH(W)) bus1 ();

   frame_serializer #(.NR_CHANNELS(NR), .INPUT_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .mute(mute),
      .clr_underrun(clr_underrun), .underrun(underrun)
   );

   frame_serializer #(.NR_CHANNELS(1), .INPUT_WIDTH(W)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .mute(mute1),
      .clr_underrun(clr1), .underrun(underrun1)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   bit   mon_en = 1'b0;
   bit   gap_watch = 1'b0;
   int   gap_cnt = 0;
   vec_t tbl [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Samples are compared at the negedge preceding the edge that transfers them.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (bus.m_ser_dv && bus.m_ser_dr) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got d=%0h ch=%0d, want no sample", bus.m_ser_d, bus.m_ser_ch);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sb_d", bus.m_ser_d, e.d);
               check("sb_ch", bus.m_ser_ch, e.ch);
            end
         end
         if (gap_watch && !bus.m_ser_dv)
            gap_cnt++;
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send_frame(input logic [NR*W-1:0] f, input logic m, input logic [NR*W-1:0] e);
      int t;
      bit ok;
      t  = 0;
      ok = 1'b0;
      bus.s_frame_d  = f;
      bus.s_frame_dv = 1'b1;
      mute           = m;
      while (!ok && t < 200) begin
         @(negedge clk);
         if (bus.s_frame_dr) begin
            ok = 1'b1;
            for (int k = 0; k < NR; k++) begin
               exp_t x;
               x.d  = e[k*W +: W];
               x.ch = CW'(k);
               q.push_back(x);
            end
         end
         @(posedge clk); #1;
         t++;
      end
      bus.s_frame_dv = 1'b0;
      mute           = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_frame_timeout: got no accept in %0d cycles, want accept", t);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NR*W-1:0] f1, f2, f3, fr;
      logic [W-1:0]    v1 [5];
      int              sent, got;

      tbl[0] = '{{24'h000001, 24'hC00000, 24'h400000}, 1'b0, {24'h000001, 24'hC00000, 24'h400000}};
      tbl[1] = '{{24'h123456, 24'h7FFFFF, 24'h800000}, 1'b0, {24'h123456, 24'h7FFFFF, 24'h800000}};
      tbl[2] = '{{24'hABCDEF, 24'h555555, 24'hFFFFFF}, 1'b1, {24'h000000, 24'h000000, 24'h000000}};
      tbl[3] = '{{24'h0F0F0F, 24'hA5A5A5, 24'h000002}, 1'b0, {24'h0F0F0F, 24'hA5A5A5, 24'h000002}};
      v1 = '{24'h100001, 24'h200002, 24'h300003, 24'h400004, 24'h500005};

      bus.s_frame_d   = '0;
      bus.s_frame_dv  = 1'b0;
      bus.m_ser_dr    = 1'b0;
      bus1.s_frame_d  = '0;
      bus1.s_frame_dv = 1'b0;
      bus1.m_ser_dr   = 1'b0;

      // Reset state
      cycles(3);
      @(negedge clk);
      check("rst_frame_dr", bus.s_frame_dr, 1'b0);
      check("rst_ser_dv", bus.m_ser_dv, 1'b0);
      check("rst_ser_ch", bus.m_ser_ch, 0);
      check("rst_ser_d", bus.m_ser_d, 0);
      check("rst_underrun", underrun, 1'b0);
      check("rst_n1_dv", bus1.m_ser_dv, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(1);
      check("post_rst_frame_dr", bus.s_frame_dr, 1'b1);
      mon_en = 1'b1;

      // First frame: three consecutive samples, then starvation the cycle after
      bus.m_ser_dr = 1'b1;
      send_frame(tbl[0].frame, tbl[0].m, tbl[0].exp);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("f0_dv_run", bus.m_ser_dv, 1'b1);
      end
      @(negedge clk);
      check("f0_dv_end", bus.m_ser_dv, 1'b0);
      check("f0_underrun_not_yet", underrun, 1'b0);
      @(negedge clk);
      check("f0_underrun_set", underrun, 1'b1);

      // Underrun clear and set-wins conflict
      @(posedge clk); #1;
      bus.m_ser_dr = 1'b0;
      clr_underrun = 1'b1;
      cycles(1);
      check("clr_underrun", underrun, 1'b0);
      clr_underrun = 1'b0;
      bus.m_ser_dr = 1'b1;
      cycles(1);
      check("underrun_reset", underrun, 1'b1);
      clr_underrun = 1'b1;
      cycles(1);
      check("underrun_set_wins", underrun, 1'b1);
      bus.m_ser_dr = 1'b0;
      cycles(1);
      clr_underrun = 1'b0;
      check("underrun_clr_again", underrun, 1'b0);

      // Table rows: mute only affects the frame written while it is high
      bus.m_ser_dr = 1'b1;
      for (int i = 1; i < 4; i++)
         send_frame(tbl[i].frame, tbl[i].m, tbl[i].exp);
      cycles(12);
      check("tbl_drained", q.size(), 0);

      // Backpressure: two frames buffered, third held, head sample stable
      f1 = {24'h000013, 24'h000012, 24'h000011};
      f2 = {24'h000023, 24'h000022, 24'h000021};
      f3 = {24'h000033, 24'h000032, 24'h000031};
      bus.m_ser_dr = 1'b0;
      fork
         begin
            send_frame(f1, 1'b0, f1);
            send_frame(f2, 1'b0, f2);
            send_frame(f3, 1'b0, f3);
         end
         begin
            repeat (3) @(posedge clk);
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               check("bp_hold_d", bus.m_ser_d, 24'h000011);
               check("bp_hold_ch", bus.m_ser_ch, 0);
               check("bp_frame_dr_low", bus.s_frame_dr, 1'b0);
            end
            @(posedge clk); #1;
            bus.m_ser_dr = 1'b1;
         end
      join
      cycles(15);
      check("bp_drained", q.size(), 0);

      // Continuous stream: no idle cycles, no underrun
      bus.m_ser_dr = 1'b0;
      clr_underrun = 1'b1;
      cycles(1);
      clr_underrun = 1'b0;
      fr = {$urandom, $urandom, $urandom};
      send_frame(fr, 1'b0, fr);
      bus.m_ser_dr = 1'b1;
      gap_cnt   = 0;
      gap_watch = 1'b1;
      for (int i = 1; i < 100; i++) begin
         fr = {$urandom, $urandom, $urandom};
         send_frame(fr, 1'b0, fr);
      end
      gap_watch = 1'b0;
      check("stream_gaps", gap_cnt, 0);
      check("stream_underrun", underrun, 1'b0);
      cycles(10);
      check("stream_drained", q.size(), 0);

      // Reset after ch1 of a frame has transferred
      fr = {24'h0000C3, 24'h0000C2, 24'h0000C1};
      send_frame(fr, 1'b0, fr);
      cycles(2);
      rst = 1'b1;
      q.delete();
      cycles(1);
      check("midrst_dv", bus.m_ser_dv, 1'b0);
      check("midrst_ch", bus.m_ser_ch, 0);
      check("midrst_d", bus.m_ser_d, 0);
      check("midrst_underrun", underrun, 1'b0);
      check("midrst_frame_dr", bus.s_frame_dr, 1'b0);
      rst = 1'b0;
      cycles(1);
      fr = {24'h0000D3, 24'h0000D2, 24'h0000D1};
      send_frame(fr, 1'b0, fr);
      cycles(8);
      check("midrst_drained", q.size(), 0);

      // Single-channel build: every transfer pops a frame, channel stays 0
      sent = 0;
      got  = 0;
      bus1.m_ser_dr = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         bus1.s_frame_dv = (sent < 5);
         bus1.s_frame_d  = v1[sent % 5];
         @(negedge clk);
         if (bus1.m_ser_dv && bus1.m_ser_dr) begin
            check("n1_d", bus1.m_ser_d, v1[got]);
            check("n1_ch", bus1.m_ser_ch, 0);
            got++;
         end
         if (bus1.s_frame_dv && bus1.s_frame_dr)
            sent++;
         @(posedge clk); #1;
      end
      bus1.s_frame_dv = 1'b0;
      check("n1_count", got, 5);

      bus1.m_ser_dr   = 1'b0;
      bus1.s_frame_dv = 1'b1;
      bus1.s_frame_d  = 24'h111111;
      cycles(1);
      bus1.s_frame_d  = 24'h222222;
      cycles(1);
      bus1.s_frame_d  = 24'h333333;
      @(negedge clk);
      check("n1_full_dr", bus1.s_frame_dr, 1'b0);
      check("n1_full_d", bus1.m_ser_d, 24'h111111);
      @(posedge clk); #1;
      bus1.s_frame_dv = 1'b0;
      bus1.m_ser_dr   = 1'b1;
      @(negedge clk);
      check("n1_pop0", bus1.m_ser_d, 24'h111111);
      @(posedge clk); #1;
      @(negedge clk);
      check("n1_pop1", bus1.m_ser_d, 24'h222222);
      check("n1_pop1_ch", bus1.m_ser_ch, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("n1_empty", bus1.m_ser_dv, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Transmit-side source for the channel-interleaved sample stream consumed by the interpolator (data/ch/dv/dr interface). Accepts one parallel frame holding a sample for every channel, buffers up to two frames, and emits the samples one per transfer in channel order 0..NR_CHANNELS-1 with the channel index attached. Sits between audio frame producers (I2S/TDM receivers, generators) and interpolator/mixer inputs. Reports output starvation.

Parameters:
NR_CHANNELS, 3, number of channels per frame (>=1)
INPUT_WIDTH, 24, sample width in bits, two's complement
CHW, derived localparam = max(1, $clog2(NR_CHANNELS)), channel index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_frame_d  in  NR_CHANNELS*INPUT_WIDTH  frame; channel k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]
s_frame_dv  in  1  frame valid
s_frame_dr  out  1  frame ready
mute  in  1  zero samples of frames accepted while high
m_ser_d  out  INPUT_WIDTH  serial sample
m_ser_ch  out  CHW  channel index of m_ser_d
m_ser_dv  out  1  sample valid
m_ser_dr  in  1  sample ready from downstream
clr_underrun  in  1  clears underrun flag
underrun  out  1  sticky starvation flag

Behaviour:
- Only clk and rst, one clock domain; reset is synchronous and active-high.
- Transfer on either interface = rising edge with dv && dr both high.
- Storage: two frame slots, write ptr, read ptr, count (0..2), channel counter ch, armed flag.
- s_frame_dr = (count != 2), from registers only. Frame accepted while count==2 is impossible; count==2 with simultaneous last-channel output transfer still shows dr low that cycle.
- Frame write: slot[wr] <= mute ? 0 : s_frame_d; wr toggles; count++; armed <= 1. mute sampled only at write; buffered frames unaffected.
- m_ser_dv = (count != 0); m_ser_d = slot[rd][ch]; m_ser_ch = ch. All outputs register-driven, no combinational input-to-output path.
- Output transfer: ch++; when ch == NR_CHANNELS-1: ch <= 0, rd toggles, count--.
- Simultaneous frame write and last-channel pop: count unchanged.
- Latency: frame accepted at edge N -> m_ser_dv high, ch 0, after edge N (empty buffer case). Back-to-back with continuous m_ser_dr: no idle cycle between frames if next frame is accepted at least one cycle before last channel of current frame is popped.
- While m_ser_dv && !m_ser_dr: m_ser_d, m_ser_ch held stable.
- NR_CHANNELS==1: ch constantly 0; every output transfer pops a frame.
- underrun: set at edge where armed && m_ser_dr && count==0; cleared by clr_underrun; set wins on same-cycle conflict.
- Reset values: s_frame_dr 0 during rst, 1 first cycle after; m_ser_dv 0; m_ser_ch 0; m_ser_d 0 (slots cleared); underrun 0; count, wr, rd, ch, armed 0.
- rst mid-frame: partially sent frame and buffered frames discarded; next accepted frame starts at ch 0.

Decomposition:
- Shared package soneo_stream_pkg: chw(nr_channels) function (max(1,clog2)), frame slice helper function, sample_t parameterized width constant conventions.
- One sub-module: frame_buf2 (two-slot frame ping-pong with wr/rd/count, write/pop strobes, full/empty); ch counter, mute, underrun stay in top.

Test Plan:
- Reset, one frame {ch0=0x400000, ch1=0xC00000, ch2=0x000001}, m_ser_dr=1 -> three consecutive dv cycles, ch 0,1,2 with those values, then dv=0; underrun=1 the following cycle.
- m_ser_dr=0, offer 3 frames -> first two accepted, s_frame_dr=0 after second, third held; m_ser_d=frame1 ch0 stable throughout; releasing dr -> 6 samples in order, third frame accepted after frame1 ch2 pops.
- Frames offered every 3 cycles, m_ser_dr=1 continuous, 100 frames -> zero gap cycles, ch sequence 0,1,2 repeating, underrun stays 0.
- After underrun set, clr_underrun pulse -> underrun=0 next cycle; clr and set same cycle -> underrun remains 1.
- mute=1 only during frame 2 acceptance -> frame 1 values intact, frame 2 outputs 0x000000 for ch 0..2, frame 3 intact.
- rst pulse after ch1 of a frame transferred -> next cycle m_ser_dv=0, m_ser_ch=0, underrun=0; new frame emits from ch 0; NR_CHANNELS=1 build: each transfer pops one frame, m_ser_ch=0.
